karat_mult_feeder: RTL
======================

# karat_mult_feeder

Operand-loading and result-capture controller that sits directly in front of the recursive Karatsuba multiplier. It assembles two wI-bit operands from a narrow valid/ready word stream and holds them stable on the multiplier's operand inputs. It drives the multiplier enable, captures the 2·wI-bit product when the multiplier signals finish, and presents the product on a valid/ready output. The controller serialises jobs: one operand pair in flight at a time.

## Interface

Parameters:
- wI, 1024, operand width; must equal the multiplier's wI.
- wW, 64, input word width; wI % wW == 0 is required.
- nW (localparam), wI/wW, number of words per operand.

Ports:
- clk  in  1  single clock, all state on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- s_data  in  wW  operand word, least-significant word first.
- s_valid  in  1  s_data valid.
- s_ready  out  1  word accepted when s_valid && s_ready.
- oX  out  wI  operand X, drives the multiplier iX.
- oY  out  wI  operand Y, drives the multiplier iY.
- o_enable  out  1  drives the multiplier i_enable.
- i_finish  in  1  from the multiplier o_finish.
- iO  in  2·wI  from the multiplier oO.
- m_prod  out  2·wI  captured product.
- m_valid  out  1  m_prod valid.
- m_ready  in  1  product consumed when m_valid && m_ready.

## Operation

The controller has four states: LOAD_X, LOAD_Y, RUN and DRAIN. It resets to LOAD_X.

Word counter:
- wcnt counts 0..nW-1.
- It advances only on an accepted word.
- It wraps to 0 after word nW-1.

LOAD_X:
- s_ready = 1.
- An accepted word writes oX[wcnt·wW +: wW].
- On the accept with wcnt == nW-1, go to LOAD_Y.

LOAD_Y:
- Behaves like LOAD_X, but writes oY.
- On the last accept, go to RUN and set o_enable <= 1.

RUN:
- s_ready = 0.
- oX, oY and o_enable are held constant.
- When i_finish == 1 and (m_valid == 0 || m_ready == 1):
  - m_prod <= iO, m_valid <= 1, o_enable <= 0.
  - Go to DRAIN.
- When i_finish == 1 but the output slot is occupied and not being consumed, stay in RUN. Enable and operands remain held, so iO stays valid.

DRAIN:
- s_ready = 0.
- Wait for i_finish == 0, then go to LOAD_X. This prevents a stale finish from being taken as completion of the next job.

Output handshake:
- m_valid clears on m_valid && m_ready, unless a new capture happens in the same cycle, in which case it stays 1 with the new data.
- m_prod is unchanged while m_valid == 1 and m_ready == 0.

Other rules:
- No arithmetic is done here. iO is captured verbatim at full 2·wI width.
- oX and oY keep their last values after a job; they are overwritten word by word on the next load.

## Timing

Reset values (asynchronous, apply immediately when rst_n falls):
- State = LOAD_X, wcnt = 0.
- oX = 0, oY = 0, o_enable = 0.
- m_prod = 0, m_valid = 0.
- s_ready = 1 once reset is released.

Latency:
- Loading takes 2·nW accepted words; with continuous s_valid that is 2·nW cycles.
- o_enable rises on the edge that accepts the last Y word.
- The multiplier raises i_finish nSTAGE cycles later.
- m_valid rises on the first edge where i_finish == 1 and the output slot is free.
- DRAIN lasts nSTAGE cycles, because the multiplier's finish chain decays.

Handshake and boundary rules:
- Bubbles on s_valid stall loading without corrupting wcnt.
- s_data is ignored whenever s_ready == 0.
- Reset mid-load or mid-run abandons the job: partial words are discarded and no m_valid is produced. The multiplier shares rst_n, so its finish chain also clears.
- A new job may load while m_valid == 1 from the previous job. Capture of that new job waits until the slot frees.

## Test plan

All scenarios use wI = 8, wW = 4 (nW = 2) and multiplier nSTAGE = 1.

1. Words 0x5, 0xA, 0xC, 0x3 with m_ready = 1 -> oX = 0xA5, oY = 0x3C; o_enable high 1 cycle later; m_valid pulses with m_prod = 0x26AC; state returns to LOAD_X after DRAIN.
2. X = Y = 0xFF -> m_prod = 0xFE01. X = 0x00, Y = 0x7F -> m_prod = 0x0000.
3. Insert 3-cycle s_valid gaps between every word of scenario 1 -> same m_prod = 0x26AC; wcnt never skips; s_ready stays 1 throughout the load.
4. Hold m_ready = 0 for 10 cycles after job 1, then load job 2 (0xFF × 0xFF):
   - m_prod holds 0x26AC.
   - Job 2 stays in RUN with o_enable = 1.
   - Releasing m_ready yields 0x26AC and then 0xFE01, in order, with no loss.
5. Assert rst_n low after 3 words are accepted -> all outputs zero and s_ready = 1 after release; a fresh load of scenario 1's 4 words produces exactly one m_valid with 0x26AC.
6. Assert s_valid during RUN and DRAIN with junk data 0xF -> no accept (s_ready = 0); oX and oY unchanged; result is correct.

Source files
------------

// File: rtl/karat_mult_feeder.sv
// Purpose: assembles two wI-bit operands from a wW-bit word stream, runs one Karatsuba job at a time, captures the product.
// Latency: 2*nW accepted words to load, then o_enable until i_finish; product registered on the first free-slot finish edge.
// Backpressure: s_ready low outside loading; a finish is held off (operands/enable frozen) while m_valid && !m_ready.
module karat_mult_feeder #(
    parameter int wI = 1024,
    parameter int wW = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [wW-1:0]     s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [wI-1:0]     oX,
    output logic [wI-1:0]     oY,
    output logic              o_enable,
    input  logic              i_finish,
    input  logic [2*wI-1:0]   iO,
    output logic [2*wI-1:0]   m_prod,
    output logic              m_valid,
    input  logic              m_ready
);
    localparam int nW = wI / wW;
    localparam int wC = (nW > 1) ? $clog2(nW) : 1;

    typedef enum logic [1:0] {LOAD_X, LOAD_Y, RUN, DRAIN} state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [wC-1:0]       r_wcnt;
    logic [wI-1:0]       r_x;
    logic [wI-1:0]       r_y;
    logic                r_enable;
    logic [2*wI-1:0]     r_prod;
    logic                r_valid;

    logic                w_accept;
    logic                w_last;
    logic                w_slot_free;
    logic                w_capture;

    assign w_accept    = s_valid && s_ready;
    assign w_last      = (r_wcnt == wC'(nW - 1));
    assign w_slot_free = !r_valid || m_ready;
    assign w_capture   = (r_state == RUN) && i_finish && w_slot_free;

    assign oX       = r_x;
    assign oY       = r_y;
    assign o_enable = r_enable;
    assign m_prod   = r_prod;
    assign m_valid  = r_valid;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= LOAD_X;
        else        r_state <= w_state_nxt;
    end

    // Next-state: DRAIN waits for the finish chain to decay so a stale finish is never seen as the next job's completion
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            LOAD_X:  if (w_accept && w_last) w_state_nxt = LOAD_Y;
            LOAD_Y:  if (w_accept && w_last) w_state_nxt = RUN;
            RUN:     if (w_capture)          w_state_nxt = DRAIN;
            DRAIN:   if (!i_finish)          w_state_nxt = LOAD_X;
            default:                         w_state_nxt = LOAD_X;
        endcase
    end

    // Outputs decoded from state: words are only taken while loading
    always_comb begin
        s_ready = (r_state == LOAD_X) || (r_state == LOAD_Y);
    end

    // Word counter advances on accepted words only, wrapping after the last word of each operand
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wcnt <= '0;
        end else if (w_accept) begin
            r_wcnt <= w_last ? '0 : r_wcnt + 1'b1;
        end
    end

    // Operand registers: written word by word, otherwise held so the multiplier sees stable inputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x <= '0;
            r_y <= '0;
        end else if (w_accept) begin
            if (r_state == LOAD_X) r_x[int'(r_wcnt)*wW +: wW] <= s_data;
            else                   r_y[int'(r_wcnt)*wW +: wW] <= s_data;
        end
    end

    // Enable rises with the last Y word and drops on capture; held through a blocked finish
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_enable <= 1'b0;
        end else if (r_state == LOAD_Y && w_accept && w_last) begin
            r_enable <= 1'b1;
        end else if (w_capture) begin
            r_enable <= 1'b0;
        end
    end

    // Output slot: capture overrides a same-cycle consume, data frozen while stalled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prod  <= '0;
            r_valid <= 1'b0;
        end else if (w_capture) begin
            r_prod  <= iO;
            r_valid <= 1'b1;
        end else if (r_valid && m_ready) begin
            r_valid <= 1'b0;
        end
    end

endmodule
